// File: rtl/serial_pattern_sequencer_if.sv
// Bundle between the sequencer, its lab-side controller and the sequence-detector datapath.
// The slave modport is the sequencer's view. The master modport is the view of the controller plus the detector.
interface serial_pattern_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             z_in;
    logic             w_out;
    logic             det_reset;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hit_count;
    logic             sat;

    modport slave (
        input  start, data_in, z_in,
        output w_out, det_reset, busy, done, hit_count, sat
    );

    modport master (
        output start, data_in, z_in,
        input  w_out, det_reset, busy, done, hit_count, sat
    );
endinterface

// File: rtl/serial_pattern_sequencer.sv
// Sequencer that clears the detector and shifts a test word out MSB-first on w_out.
// It counts detector hits that fall in the latency-shifted response window and reports the count with a done pulse.
module serial_pattern_sequencer #(
    parameter int WIDTH   = 8,
    parameter int CNT_W   = 4,
    parameter int DET_LAT = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    serial_pattern_sequencer_if.slave     bus
);
    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, DONE} state_t;

    localparam int WIN_W = $clog2(WIDTH + DET_LAT + 1);
    localparam logic [WIN_W-1:0] SHIFT_LAST = WIN_W'(WIDTH - 1);
    localparam logic [WIN_W-1:0] DRAIN_LAST = WIN_W'(WIDTH + DET_LAT - 1);
    localparam logic [WIN_W-1:0] WIN_FIRST  = WIN_W'(DET_LAT);
    localparam logic [CNT_W-1:0] HIT_MAX    = {CNT_W{1'b1}};

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shreg;
    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] hit_count;
    logic             sat;
    logic             in_window;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // win_cnt runs from SHIFT entry through the end of DRAIN.
    // Its last value is therefore also the last response slot.
    always_comb begin
        state_next    = state;
        bus.w_out     = 1'b0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        bus.det_reset = reset;
        in_window     = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                bus.det_reset = 1'b1;
                state_next    = SHIFT;
            end
            SHIFT: begin
                bus.w_out = shreg[WIDTH-1];
                in_window = (win_cnt >= WIN_FIRST);
                if (win_cnt == SHIFT_LAST) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                in_window = (win_cnt >= WIN_FIRST);
                if (win_cnt == DRAIN_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg     <= '0;
            win_cnt   <= '0;
            hit_count <= '0;
            sat       <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                shreg     <= bus.data_in;
                hit_count <= '0;
                sat       <= 1'b0;
            end
            if (state == SHIFT) begin
                shreg <= shreg << 1;
            end
            if (state == CLEAR) begin
                win_cnt <= '0;
            end else if (state == SHIFT || state == DRAIN) begin
                win_cnt <= win_cnt + 1'b1;
            end
            // Saturate instead of wrapping, and remember that the count was clipped.
            if (in_window && bus.z_in) begin
                if (hit_count == HIT_MAX) begin
                    sat <= 1'b1;
                end else begin
                    hit_count <= hit_count + 1'b1;
                end
            end
        end
    end

    assign bus.hit_count = hit_count;
    assign bus.sat       = sat;
endmodule
